// File: rtl/round_ctrl_if.sv
// round_ctrl_if: round sequencer inputs from game logic and sequencer outputs
interface round_ctrl_if;
  logic       frame_clk;
  logic       start;
  logic       reset_round;
  logic       Red_W;
  logic       Blue_W;
  logic       clear_done;
  logic [2:0] Game_State;
  logic       clear_req;
  logic       bikes_en;
  logic [1:0] countdown_val;
  logic [1:0] winner;
  modport master (
    input  frame_clk, start, reset_round, Red_W, Blue_W, clear_done,
    output Game_State, clear_req, bikes_en, countdown_val, winner
  );
  modport slave (
    output frame_clk, start, reset_round, Red_W, Blue_W, clear_done,
    input  Game_State, clear_req, bikes_en, countdown_val, winner
  );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: Tron round sequencer (title, clear, countdown, play, freeze, win screen)
module round_ctrl #(
  parameter int COUNT_FRAMES  = 60,
  parameter int FREEZE_FRAMES = 90,
  parameter int WIN_FRAMES    = 300,
  parameter int FW            = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  round_ctrl_if.master bus
);
  localparam logic [2:0] TITLE      = 3'd0;
  localparam logic [2:0] CLEAR      = 3'd1;
  localparam logic [2:0] COUNTDOWN  = 3'd2;
  localparam logic [2:0] PLAY       = 3'd3;
  localparam logic [2:0] ROUND_OVER = 3'd4;
  localparam logic [2:0] GAME_OVER  = 3'd5;
  localparam logic [FW-1:0] CD_LAST = FW'(COUNT_FRAMES - 1);
  localparam logic [FW-1:0] FZ_LAST = FW'(FREEZE_FRAMES - 1);
  localparam logic [FW-1:0] WN_LAST = FW'(WIN_FRAMES - 1);
  logic [2:0]    state;
  logic [2:0]    f_sync, s_sync;
  logic          frame_tick, start_edge;
  logic [FW-1:0] cnt;
  logic [1:0]    latch, latch_nx, w;
  logic          clear_req, bikes_en;
  logic [1:0]    cd, winner;
  assign frame_tick = f_sync[1] & ~f_sync[2];
  assign start_edge = s_sync[1] & ~s_sync[2];
  assign w          = {bus.Blue_W, bus.Red_W};
  assign latch_nx   = latch | w;
  assign bus.Game_State    = state;
  assign bus.clear_req     = clear_req;
  assign bus.bikes_en      = bikes_en;
  assign bus.countdown_val = cd;
  assign bus.winner        = winner;
  // two-flop synchronisers with a third flop for rising-edge detection
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      f_sync <= '0;
      s_sync <= '0;
    end else begin
      f_sync <= {f_sync[1:0], bus.frame_clk};
      s_sync <= {s_sync[1:0], bus.start};
    end
  // round sequencer; every state entry zeroes the frame counter
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state     <= TITLE;
      clear_req <= 1'b0;
      bikes_en  <= 1'b0;
      cd        <= 2'd0;
      winner    <= 2'd0;
      cnt       <= '0;
      latch     <= 2'd0;
    end else begin
      case (state)
        TITLE:
          if (start_edge) begin
            state     <= CLEAR;
            clear_req <= 1'b1;
            latch     <= 2'd0;
            cnt       <= '0;
          end
        CLEAR:
          if (bus.clear_done) begin
            state     <= COUNTDOWN;
            clear_req <= 1'b0;
            cnt       <= '0;
            cd        <= 2'd3;
          end
        COUNTDOWN:
          if (frame_tick) begin
            if (cnt == CD_LAST) begin
              cnt <= '0;
              cd  <= cd - 2'd1;
              if (cd == 2'd1) begin
                state    <= PLAY;
                bikes_en <= 1'b1;
              end
            end else cnt <= cnt + 1'b1;
          end
        PLAY:
          if (bus.reset_round || w != 2'd0) begin
            state    <= ROUND_OVER;
            bikes_en <= 1'b0;
            cnt      <= '0;
            latch    <= latch_nx;
          end
        ROUND_OVER: begin
          latch <= latch_nx;
          if (frame_tick) begin
            if (cnt == FZ_LAST) begin
              cnt <= '0;
              if (latch_nx != 2'd0) begin
                state  <= GAME_OVER;
                winner <= latch_nx;
              end else begin
                state     <= CLEAR;
                clear_req <= 1'b1;
              end
            end else cnt <= cnt + 1'b1;
          end
        end
        GAME_OVER:
          if (frame_tick) begin
            if (cnt == WN_LAST) begin
              cnt    <= '0;
              state  <= TITLE;
              winner <= 2'd0;
            end else cnt <= cnt + 1'b1;
          end
        default: begin
          state     <= TITLE;
          clear_req <= 1'b0;
          bikes_en  <= 1'b0;
          cd        <= 2'd0;
          winner    <= 2'd0;
          cnt       <= '0;
        end
      endcase
    end
endmodule
